jk_drive_ctrl: RTL and testbench
================================

Name: jk_drive_ctrl

Overview:
Transition driver for a bank of WIDTH jkff-style registers. It accepts a target state vector over a valid/ready handshake and reads back the bank's current Q. It derives J/K drive per bit from the JK excitation table and pulses it for one clock. It then waits for the bank to settle, verifies the read-back, and retries or flags an error.

Parameters:
WIDTH, 8, number of JK flops driven (1..32)
SETTLE, 2, wait cycles between drive pulse and verify (>=1)
MAX_RETRY, 2, extra drive attempts after a failed verify (0..15)

Ports:
CLK  input  1  clock, rising edge
RESET_N  input  1  synchronous reset, active low
TGT_VALID  input  1  target vector valid
TGT_READY  output  1  controller can accept a target (high only in IDLE)
TGT  input  WIDTH  desired Q vector
Q_FB  input  WIDTH  Q read back from the flop bank
J  output  WIDTH  J drive to bank, registered
K  output  WIDTH  K drive to bank, registered
BUSY  output  1  high in any state other than IDLE
DONE  output  1  one-cycle completion pulse
ERR  output  1  valid only with DONE; 1 = target not reached after all retries

Behaviour:
- Reset (RESET_N low at a rising edge, any state, including mid-drive): state=IDLE, J=K=0, DONE=0, ERR=0, BUSY=0, retry count=0. TGT_READY=1 from the next cycle.
- States: IDLE, DRIVE, WAIT, CHECK_RESULT (DONE pulse cycle).
- IDLE: TGT_READY=1. On TGT_VALID&&TGT_READY in cycle N, register TGT into tgt_q and sample Q_FB.
  - If Q_FB==TGT: go to CHECK_RESULT. DONE=1, ERR=0 in cycle N+1. J/K stay 0.
  - Else: compute J/K from (Q_FB, TGT) and go to DRIVE.
- Excitation, default fill:
  - 0->1: J=1, K=0
  - 1->0: J=0, K=1
  - 0->0 and 1->1: J=0, K=0
  - J&K is never 1 on any bit.
- DRIVE: J/K visible for exactly one cycle (N+1). The bank captures at the end of N+1. The next state is WAIT, and J/K return to 0 on entry.
- WAIT: counts SETTLE cycles (N+2 .. N+SETTLE+1) with J=K=0.
- Verify, at the end of the last WAIT cycle: compare Q_FB to tgt_q.
  - Match: DONE=1, ERR=0 in cycle N+SETTLE+2.
  - Mismatch with retry count < MAX_RETRY: increment the count, recompute J/K from the current Q_FB vs tgt_q, and go to DRIVE. Each retry adds SETTLE+1 cycles.
  - Mismatch with retries exhausted: DONE=1, ERR=1 in the pulse cycle.
- CHECK_RESULT: lasts one cycle, then IDLE. The retry count clears.
- DONE/ERR are 0 in all other cycles. TGT_VALID outside IDLE is ignored; no capture takes place.
- TGT and Q_FB are sampled only at the documented edges. Changes at other times have no effect.
- Back-to-back: a new target is accepted in the first IDLE cycle after the DONE pulse. Minimum spacing is 2 cycles for the skip case.

Optional Feature:
JK_TOGGLE_EN:
- Defined: each changing bit drives J=1, K=1 (toggle); unchanged bits drive 0,0. The retry recompute still uses current Q_FB, so a double toggle is corrected.
- Undefined: set/reset fill as above. No bit ever drives J=K=1.

Test Plan:
- Reset, then WIDTH=8, SETTLE=2, bench model of an 8-bit jkff bank starting at 0x00. Send TGT=0xA5 -> J=0xA5, K=0x00 in cycle N+1 only; DONE=1, ERR=0 in N+4; Q_FB=0xA5.
- Bank at 0xA5, send TGT=0x3C -> J=0x18, K=0x81 in N+1; DONE in N+4, ERR=0. With JK_TOGGLE_EN: J=K=0x99.
- Bank at 0x3C, send TGT=0x3C -> no J/K activity; DONE=1, ERR=0 in N+1; TGT_READY back to 1 in N+2.
- Bank bit 0 stuck at 0, send TGT=0x01 from 0x00, MAX_RETRY=2:
  - Three drive pulses J=0x01, at N+1, N+4 and N+7.
  - DONE=1, ERR=1 in N+10.
- Stuck bit released after the first pulse -> second pulse succeeds; DONE=1, ERR=0 in N+7.
- Assert RESET_N low during WAIT -> next cycle IDLE, J=K=0, BUSY=0, no DONE pulse. A fresh target then completes normally.

Source files
------------

// File: rtl/jk_drive_ctrl_if.sv
// Handshake and drive bundle between the JK transition controller and its
// environment: target request (TGT_VALID/TGT_READY/TGT), the bank read-back
// (Q_FB), the registered J/K drive and the BUSY/DONE/ERR status.
// master = requester/bank side, slave = jk_drive_ctrl.
interface jk_drive_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             TGT_VALID;
  logic             TGT_READY;
  logic [WIDTH-1:0] TGT;
  logic [WIDTH-1:0] Q_FB;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             BUSY;
  logic             DONE;
  logic             ERR;

  modport master (
    output TGT_VALID, TGT, Q_FB,
    input  TGT_READY, J, K, BUSY, DONE, ERR
  );

  modport slave (
    input  TGT_VALID, TGT, Q_FB,
    output TGT_READY, J, K, BUSY, DONE, ERR
  );
endinterface

// File: rtl/jk_drive_ctrl.sv
// Transition driver for a bank of WIDTH JK flip-flops.
// Accepts a target vector, derives per-bit J/K from the JK excitation table,
// pulses it for one clock, waits SETTLE cycles, verifies the read-back and
// either completes, retries (up to MAX_RETRY times) or reports ERR with DONE.
// Optional build macro JK_TOGGLE_EN: changing bits are driven with J=K=1
// (toggle) instead of the default set/reset fill.
module jk_drive_ctrl #(
  parameter int WIDTH     = 8,
  parameter int SETTLE    = 2,
  parameter int MAX_RETRY = 2
) (
  input logic            CLK,
  input logic            RESET_N,
  jk_drive_ctrl_if.slave bus
);

  localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CHECK_RESULT
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
  } jk_t;

  // J/K needed to move the bank from q to t.
  function automatic jk_t excite(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
    jk_t r;
`ifdef JK_TOGGLE_EN
    r.j = q ^ t;
    r.k = q ^ t;
`else
    r.j = ~q & t;
    r.k = q & ~t;
`endif
    return r;
  endfunction

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] tgt_q,     tgt_d;
  logic [WIDTH-1:0] j_q,       j_d;
  logic [WIDTH-1:0] k_q,       k_d;
  logic             done_q,    done_d;
  logic             err_q,     err_d;
  logic [WAIT_W-1:0] wait_q,   wait_d;
  logic [3:0]       retry_q,   retry_d;

  jk_t              drive_new;
  jk_t              drive_retry;

  // Excitation for a fresh request and for a retry from the current read-back.
  always_comb begin
    drive_new   = excite(bus.Q_FB, bus.TGT);
    drive_retry = excite(bus.Q_FB, tgt_q);
  end

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    tgt_d   = tgt_q;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wait_d  = wait_q;
    retry_d = retry_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.TGT_VALID) begin
          tgt_d   = bus.TGT;
          retry_d = '0;
          if (bus.Q_FB == bus.TGT) begin
            // Already there: skip the drive and report success next cycle.
            state_d = ST_CHECK_RESULT;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRIVE;
            j_d     = drive_new.j;
            k_d     = drive_new.k;
          end
        end
      end

      ST_DRIVE: begin
        // J/K were visible for this one cycle; they fall back to 0 via defaults.
        state_d = ST_WAIT;
        wait_d  = '0;
      end

      ST_WAIT: begin
        if (wait_q == WAIT_W'(SETTLE - 1)) begin
          if (bus.Q_FB == tgt_q) begin
            state_d = ST_CHECK_RESULT;
            done_d  = 1'b1;
          end else if (retry_q < 4'(MAX_RETRY)) begin
            state_d = ST_DRIVE;
            retry_d = retry_q + 4'd1;
            j_d     = drive_retry.j;
            k_d     = drive_retry.k;
          end else begin
            state_d = ST_CHECK_RESULT;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      ST_CHECK_RESULT: begin
        state_d = ST_IDLE;
        retry_d = '0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      retry_q <= retry_d;
    end
  end

  assign bus.TGT_READY = (state_q == ST_IDLE);
  assign bus.BUSY      = (state_q != ST_IDLE);
  assign bus.J         = j_q;
  assign bus.K         = k_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_jk_drive_ctrl.sv
// Directed bench for jk_drive_ctrl (WIDTH=8, SETTLE=2, MAX_RETRY=2) driving a
// model 8-bit JK bank with an optional stuck-at-0 mask. Inputs change and
// outputs are sampled on the falling edge.
module tb_jk_drive_ctrl;

`ifdef JK_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bank_q = 8'h00;
  logic [7:0] stuck;
  int         total = 0;
  int         bad   = 0;

  jk_drive_ctrl_if #(.WIDTH(8)) bus ();

  jk_drive_ctrl #(.WIDTH(8), .SETTLE(2), .MAX_RETRY(2)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.Q_FB = bank_q;

  // Model of the JK bank: standard JK next-state per bit, stuck bits forced 0.
  always @(posedge clk) begin
    logic [7:0] nxt;
    for (int b = 0; b < 8; b++) begin
      case ({bus.J[b], bus.K[b]})
        2'b10:   nxt[b] = 1'b1;
        2'b01:   nxt[b] = 1'b0;
        2'b11:   nxt[b] = ~bank_q[b];
        default: nxt[b] = bank_q[b];
      endcase
    end
    bank_q <= nxt & ~stuck;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // set/rst are the set/reset excitation masks; toggle builds drive both.
  task automatic outs(input string tag, input logic [7:0] set, input logic [7:0] rst,
                      input logic busy, input logic done, input logic err,
                      input logic ready);
    chk({tag, ".J"},     32'(bus.J), 32'(TOG ? (set | rst) : set));
    chk({tag, ".K"},     32'(bus.K), 32'(TOG ? (set | rst) : rst));
    chk({tag, ".BUSY"},  32'(bus.BUSY), 32'(busy));
    chk({tag, ".DONE"},  32'(bus.DONE), 32'(done));
    chk({tag, ".ERR"},   32'(bus.ERR), 32'(err));
    chk({tag, ".READY"}, 32'(bus.TGT_READY), 32'(ready));
  endtask

  // Offer a target in the current (IDLE) cycle N; returns in cycle N+1.
  task automatic send(input string tag, input logic [7:0] t);
    chk({tag, ".accept_ready"}, 32'(bus.TGT_READY), 32'd1);
    bus.TGT_VALID = 1'b1;
    bus.TGT       = t;
    @(negedge clk);
    bus.TGT_VALID = 1'b0;
    bus.TGT       = 8'hFF;
  endtask

  initial begin
    bus.TGT_VALID = 1'b0;
    bus.TGT       = 8'h00;
    stuck         = 8'h00;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    outs("reset", 8'h00, 8'h00, 0, 0, 0, 1);

    // 0x00 -> 0xA5: drive in N+1 only, DONE in N+4.
    send("t1", 8'hA5);
    outs("t1_n1", 8'hA5, 8'h00, 1, 0, 0, 0);
    @(negedge clk); outs("t1_n2", 8'h00, 8'h00, 1, 0, 0, 0);
    @(negedge clk); outs("t1_n3", 8'h00, 8'h00, 1, 0, 0, 0);
    @(negedge clk); outs("t1_n4", 8'h00, 8'h00, 1, 1, 0, 0);
    @(negedge clk); outs("t1_n5", 8'h00, 8'h00, 0, 0, 0, 1);
    chk("t1_bank", 32'(bank_q), 32'h A5);

    // 0xA5 -> 0x3C: set 0x18, reset 0x81 (toggle 0x99).
    send("t2", 8'h3C);
    outs("t2_n1", 8'h18, 8'h81, 1, 0, 0, 0);
    @(negedge clk); outs("t2_n2", 8'h00, 8'h00, 1, 0, 0, 0);
    @(negedge clk); outs("t2_n3", 8'h00, 8'h00, 1, 0, 0, 0);
    @(negedge clk); outs("t2_n4", 8'h00, 8'h00, 1, 1, 0, 0);
    @(negedge clk); outs("t2_n5", 8'h00, 8'h00, 0, 0, 0, 1);
    chk("t2_bank", 32'(bank_q), 32'h3C);

    // 0x3C -> 0x3C: skip, DONE in N+1, ready again in N+2; mid-cycle TGT noise ignored.
    send("t3", 8'h3C);
    outs("t3_n1", 8'h00, 8'h00, 1, 1, 0, 0);
    @(negedge clk); outs("t3_n2", 8'h00, 8'h00, 0, 0, 0, 1);

    // Return bank to 0x00: reset 0x3C.
    send("t0", 8'h00);
    outs("t0_n1", 8'h00, 8'h3C, 1, 0, 0, 0);
    @(negedge clk); outs("t0_n2", 8'h00, 8'h00, 1, 0, 0, 0);
    @(negedge clk); outs("t0_n3", 8'h00, 8'h00, 1, 0, 0, 0);
    @(negedge clk); outs("t0_n4", 8'h00, 8'h00, 1, 1, 0, 0);
    @(negedge clk); outs("t0_n5", 8'h00, 8'h00, 0, 0, 0, 1);
    chk("t0_bank", 32'(bank_q), 32'h00);

    // Bit 0 stuck: pulses at N+1, N+4, N+7; DONE+ERR at N+10.
    stuck = 8'h01;
    send("t4", 8'h01);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      outs($sformatf("t4_n%0d", c), (c == 1 || c == 4 || c == 7) ? 8'h01 : 8'h00,
           8'h00, 1, (c == 10), (c == 10), 0);
    end
    @(negedge clk); outs("t4_n11", 8'h00, 8'h00, 0, 0, 0, 1);
    chk("t4_bank", 32'(bank_q), 32'h00);

    // Stuck released after the first pulse: second pulse lands, DONE at N+7.
    send("t5", 8'h01);
    outs("t5_n1", 8'h01, 8'h00, 1, 0, 0, 0);
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      if (c == 2) stuck = 8'h00;
      outs($sformatf("t5_n%0d", c), (c == 4) ? 8'h01 : 8'h00, 8'h00, 1, (c == 7), 0, 0);
    end
    @(negedge clk); outs("t5_n8", 8'h00, 8'h00, 0, 0, 0, 1);
    chk("t5_bank", 32'(bank_q), 32'h01);

    // Reset during WAIT: 0x01 -> 0x02 driven, reset asserted in N+2.
    send("t6", 8'h02);
    outs("t6_n1", 8'h02, 8'h01, 1, 0, 0, 0);
    @(negedge clk); outs("t6_n2", 8'h00, 8'h00, 1, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk); outs("t6_n3", 8'h00, 8'h00, 0, 0, 0, 1);
    rst_n = 1'b1;
    @(negedge clk); outs("t6_n4", 8'h00, 8'h00, 0, 0, 0, 1);
    @(negedge clk); outs("t6_n5", 8'h00, 8'h00, 0, 0, 0, 1);
    chk("t6_bank", 32'(bank_q), 32'h02);

    // Fresh target after reset: 0x02 -> 0x80.
    send("t7", 8'h80);
    outs("t7_n1", 8'h80, 8'h02, 1, 0, 0, 0);
    @(negedge clk); outs("t7_n2", 8'h00, 8'h00, 1, 0, 0, 0);
    @(negedge clk); outs("t7_n3", 8'h00, 8'h00, 1, 0, 0, 0);
    @(negedge clk); outs("t7_n4", 8'h00, 8'h00, 1, 1, 0, 0);
    @(negedge clk); outs("t7_n5", 8'h00, 8'h00, 0, 0, 0, 1);
    chk("t7_bank", 32'(bank_q), 32'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
